mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port op, input, 7 bits: instruction opcode field, instr[6:0].
REQ-004 SHALL have port funct3, input, 3 bits: instr[14:12].
REQ-005 SHALL have port funct7b5, input, 1 bit: instr[30].
REQ-006 SHALL have port zero, input, 1 bit: the ALU Z flag from the current cycle.
REQ-007 SHALL have output ports PCWrite, AdrSrc, IRWrite, MemWrite and RegWrite, 1 bit each: datapath enables and the address select.
REQ-008 SHALL have output ports ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, 2 bits each: datapath mux selects.
REQ-009 SHALL have output port ALUControl, 3 bits, encoded as 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-010 SHALL have output port state, 4 bits: the current FSM state, for debug.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, and advance exactly one state per clk.
REQ-012 SHALL always go FETCH->DECODE.
REQ-013 SHALL leave DECODE on op: 0000011 or 0100011 ->MEMADR; 0110011 ->EXECR; 0010011 ->EXECI; 1101111 ->JAL; 1100011 ->BEQ; any other op ->FETCH, with no write enable asserted.
REQ-014 SHALL go MEMADR->MEMREAD when op=0000011, else MEMADR->MEMWRITE.
REQ-015 SHALL use these remaining transitions: MEMREAD->MEMWB; EXECR, EXECI and JAL ->ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ ->FETCH.
REQ-016 SHALL drive these outputs per state; any field not listed is 0:
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCWrite=1, ALUOp add.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp add.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp add.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUOp func.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp func.
  - ALUWB: RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1, ALUOp add.
  - BEQ: ALUSrcA=10, ALUOp sub, PCWrite=zero.
REQ-017 SHALL decode ALUOp func on funct3:
  - 000: sub when op[5]&funct7b5=1, else add.
  - 010: slt.
  - 100: xor.
  - 110: or.
  - 111: and.
  - any other value: add.
REQ-018 SHALL decode ImmSrc combinationally from op: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-019 SHALL make PCWrite in BEQ the only output that depends combinationally on zero, with zero-cycle latency from zero to PCWrite.
REQ-020 SHALL make state equal the encoding of the current state register.

Reset
REQ-021 SHALL load state=FETCH at the first rising clk edge where reset=1.
REQ-022 SHALL force PCWrite, IRWrite, MemWrite and RegWrite to 0 while reset=1, in any state.
REQ-023 SHALL, on reset asserted mid-instruction in any state, abandon that instruction with no partial write; FETCH outputs resume in the first cycle with reset=0.

Configuration
REQ-024 SHALL, when MC_CTRL_BNE_EN is defined, treat BEQ state with funct3=001 as bne, driving PCWrite=~zero.
REQ-025 SHALL, when MC_CTRL_BNE_EN is undefined, drive PCWrite=zero in BEQ state regardless of funct3.

Verification
REQ-026 SHALL check reset: reset=1 for 2 cycles, then release -> state=0, PCWrite=IRWrite=1 in the first released cycle, state=1 in the next.
REQ-027 SHALL check lw: op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4.
REQ-028 SHALL check sub: op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in state 6, then state 7 with RegWrite=1.
REQ-029 SHALL check beq: op=1100011, zero=1 -> PCWrite=1 in state 10; zero=0 -> PCWrite=0; the bne case is covered only under MC_CTRL_BNE_EN.
REQ-030 SHALL check illegal op and mid-instruction reset: op=1111111 -> 0,1,0 with no enables; reset asserted in state 5 -> MemWrite=0 and state=0 next cycle.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode, memory, ALU and branch steps.
// Optional feature: define MC_CTRL_BNE_EN to resolve funct3=001 in the branch state as bne.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunc
  } alu_op_e;

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    branch_taken;
  logic    pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBeq;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecR,
      StExecI,
      StJal:      state_d = StAluWb;
      StMemWb,
      StMemWrite,
      StAluWb,
      StBeq:      state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Branch resolution: the only path from zero to an output
`ifdef MC_CTRL_BNE_EN
  assign branch_taken = (funct3 == 3'b001) ? ~zero : zero;
`else
  assign branch_taken = zero;
`endif

  // Moore outputs per state
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = AluOpAdd;
    case (state_q)
      StFetch: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      StMemWrite: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        alu_op  = AluOpFunc;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = AluOpFunc;
      end
      StAluWb: reg_write_raw = 1'b1;
      StJal: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      StBeq: begin
        ALUSrcA      = 2'b10;
        alu_op       = AluOpSub;
        pc_write_raw = branch_taken;
      end
      default: ;
    endcase
  end

  // Reset gates every write enable so an abandoned instruction leaves no trace
  assign PCWrite  = pc_write_raw & ~reset;
  assign IRWrite  = ir_write_raw & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;

  // ALU decoder
  always_comb begin
    ALUControl = AluAdd;
    case (alu_op)
      AluOpAdd: ALUControl = AluAdd;
      AluOpSub: ALUControl = AluSub;
      AluOpFunc: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? AluSub : AluAdd;
          3'b010:  ALUControl = AluSlt;
          3'b100:  ALUControl = AluXor;
          3'b110:  ALUControl = AluOr;
          3'b111:  ALUControl = AluAnd;
          default: ALUControl = AluAdd;
        endcase
      end
      default: ALUControl = AluAdd;
    endcase
  end

  // Immediate format select, independent of state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .state      (state)
  );

  wire [15:0] ctrl = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  // Number of cycles an instruction spends from FETCH until it returns to FETCH
  function automatic int path_len(input logic [6:0] o);
    case (o)
      LW:                path_len = 5;
      SW, RTY, ITY, JAL: path_len = 4;
      BEQ:               path_len = 3;
      default:           path_len = 2;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [6:0] o, input int k);
    logic [19:0] seq;
    case (o)
      LW:      seq = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      SW:      seq = {4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      RTY:     seq = {4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      ITY:     seq = {4'd0, 4'd1, 4'd8, 4'd7, 4'd0};
      JAL:     seq = {4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
      BEQ:     seq = {4'd0, 4'd1, 4'd10, 4'd0, 4'd0};
      default: seq = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    endcase
    path_state = seq[(4 - k) * 4 +: 4];
  endfunction

  // ALU operation the instruction's mnemonic asks for
  function automatic logic [2:0] alu_func(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
    case (f3)
      3'b000:  alu_func = (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  alu_func = 3'b101;
      3'b100:  alu_func = 3'b100;
      3'b110:  alu_func = 3'b011;
      3'b111:  alu_func = 3'b010;
      default: alu_func = 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7,
                                           input logic z, input logic rst);
    logic pcw, adr, irw, mw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, irw, mw, rw} = '0;
    {rs, sa, sb} = '0;
    alu = 3'b000;
    case (o)
      SW:      imm = 2'b01;
      BEQ:     imm = 2'b10;
      JAL:     imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (st)
      4'd0:  begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin sa = 2'b10; alu = alu_func(o, f3, f7); end
      4'd7:  rw = 1;
      4'd8:  begin sa = 2'b10; sb = 2'b01; alu = alu_func(o, f3, f7); end
      4'd9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      4'd10: begin
        sa = 2'b10;
        alu = 3'b001;
`ifdef MC_CTRL_BNE_EN
        pcw = (f3 == 3'b001) ? ~z : z;
`else
        pcw = z;
`endif
      end
      default: ;
    endcase
    if (rst) {pcw, irw, mw, rw} = '0;
    exp_ctrl = {pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset cycle, leaving the DUT in FETCH with reset released
  task automatic go_fetch();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 7'h00; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    tick();
    tick();
    vectors++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_enables: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got state=%0d PCWrite=%b IRWrite=%b want 0 1 1",
               state, PCWrite, IRWrite);
    end
    tick();
    vectors++;
    if (state !== 4'd1) begin
      miscompares++;
      $display("FAIL reset_decode: got state=%0d want 1", state);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    go_fetch();
    op = LW; funct3 = 3'b010;
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if (state !== seq[k] || RegWrite !== (k == 4) || (ResultSrc == 2'b01) !== (k == 4)) begin
        miscompares++;
        $display("FAIL lw_step%0d: got state=%0d RegWrite=%b ResultSrc=%b want state=%0d",
                 k, state, RegWrite, ResultSrc, seq[k]);
      end
      tick();
    end
  endtask

  task automatic test_sub();
    go_fetch();
    op = RTY; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    vectors++;
    if (state !== 4'd6 || ALUControl !== 3'b001) begin
      miscompares++;
      $display("FAIL sub_exec: got state=%0d ALUControl=%b want 6 001", state, ALUControl);
    end
    tick();
    vectors++;
    if (state !== 4'd7 || RegWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_wb: got state=%0d RegWrite=%b want 7 1", state, RegWrite);
    end
    funct7b5 = 1'b0;
  endtask

  task automatic test_beq();
    go_fetch();
    op = BEQ; funct3 = 3'b000; zero = 1'b0;
    tick();
    tick();
    zero = 1'b1;
    #1;
    vectors++;
    if (state !== 4'd10 || PCWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_taken: got state=%0d PCWrite=%b want 10 1", state, PCWrite);
    end
    zero = 1'b0;
    #1;
    vectors++;
    if (PCWrite !== 1'b0 || ALUControl !== 3'b001) begin
      miscompares++;
      $display("FAIL beq_not_taken: got PCWrite=%b ALUControl=%b want 0 001",
               PCWrite, ALUControl);
    end
`ifdef MC_CTRL_BNE_EN
    funct3 = 3'b001;
    #1;
    vectors++;
    if (PCWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL bne_taken: got PCWrite=%b want 1", PCWrite);
    end
    zero = 1'b1;
    #1;
    vectors++;
    if (PCWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL bne_not_taken: got PCWrite=%b want 0", PCWrite);
    end
    funct3 = 3'b000;
`endif
    tick();
    vectors++;
    if (state !== 4'd0) begin
      miscompares++;
      $display("FAIL beq_return: got state=%0d want 0", state);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] seq [3];
    seq = '{4'd0, 4'd1, 4'd0};
    go_fetch();
    op = 7'b1111111;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (state !== seq[k] ||
          (k == 1 && {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000)) begin
        miscompares++;
        $display("FAIL illegal_step%0d: got state=%0d enables=%b want state=%0d",
                 k, state, {PCWrite, IRWrite, MemWrite, RegWrite}, seq[k]);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    go_fetch();
    op = SW;
    tick();
    tick();
    tick();
    vectors++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_memwrite: got state=%0d MemWrite=%b want 5 1", state, MemWrite);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (MemWrite !== 1'b0 || PCWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_gate: got MemWrite=%b PCWrite=%b want 0 0", MemWrite, PCWrite);
    end
    tick();
    vectors++;
    if (state !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset_state: got state=%0d want 0", state);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_resume: got PCWrite=%b IRWrite=%b want 1 1", PCWrite, IRWrite);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] o;
    logic [3:0] es;
    logic [15:0] ec;
    logic do_rst;
    ops = '{LW, SW, RTY, ITY, JAL, BEQ};
    go_fetch();
    for (int i = 0; i < 300; i++) begin
      int pick;
      pick = $urandom_range(0, 7);
      o = (pick < 6) ? ops[pick] : 7'($urandom);
      op = o;
      funct3 = 3'($urandom);
      funct7b5 = 1'($urandom);
      for (int k = 0; k < path_len(o); k++) begin
        zero = 1'($urandom);
        do_rst = (k > 0) && ($urandom_range(0, 15) == 0);
        reset = do_rst;
        #1;
        es = path_state(o, k);
        ec = exp_ctrl(es, o, funct3, funct7b5, zero, do_rst);
        vectors++;
        if (state !== es || ctrl !== ec) begin
          miscompares++;
          $display("FAIL rand_i%0d_k%0d op=%b: got state=%0d ctrl=%h want state=%0d ctrl=%h",
                   i, k, o, state, ctrl, es, ec);
        end
        tick();
        if (do_rst) begin
          reset = 1'b0;
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub();
    test_beq();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
